// File: rtl/nios_system_gpio_pkg.sv
// ---------------------------------------------------------------------------
// nios_system_gpio_pkg
//   Shared constants for the GPIO interrupt controller: Avalon word addresses
//   of the register map and the IRQ source selection values.
// ---------------------------------------------------------------------------
package nios_system_gpio_pkg;

   // Register map (Avalon word addresses). Addresses 1 and 7 are unmapped.
   localparam logic [2:0] ADDR_DATA = 3'd0;  // debounced input, read-only
   localparam logic [2:0] ADDR_MASK = 3'd2;  // irq_mask
   localparam logic [2:0] ADDR_EDGE = 3'd3;  // edge capture, write-1-to-clear
   localparam logic [2:0] ADDR_RISE = 3'd4;  // rising-edge enable
   localparam logic [2:0] ADDR_FALL = 3'd5;  // falling-edge enable
   localparam logic [2:0] ADDR_DBP  = 3'd6;  // debounce period

   // IRQ source selection.
   localparam int IRQ_MODE_LEVEL = 0;  // irq follows the debounced input
   localparam int IRQ_MODE_EDGE  = 1;  // irq follows the edge capture register

endpackage

// File: rtl/nios_system_gpio_irq_ctrl_if.sv
// ---------------------------------------------------------------------------
// nios_system_gpio_irq_ctrl_if
//   Avalon-MM slave bus of the GPIO interrupt controller.
//   address    : word address
//   chipselect : slave select
//   write_n    : write strobe, active low
//   writedata  : write data
//   readdata   : registered read data, one cycle after address
// ---------------------------------------------------------------------------
interface nios_system_gpio_irq_ctrl_if;

   logic [2:0]  address;
   logic        chipselect;
   logic        write_n;
   logic [31:0] writedata;
   logic [31:0] readdata;

   modport master (
      output address, chipselect, write_n, writedata,
      input  readdata
   );

   modport slave (
      input  address, chipselect, write_n, writedata,
      output readdata
   );

endinterface

// File: rtl/nios_system_gpio_sync_debounce.sv
// ---------------------------------------------------------------------------
// nios_system_gpio_sync_debounce
//   Synchronises WIDTH asynchronous inputs and optionally debounces them.
//   A shared prescaler ticks once every db_period cycles; on each tick a bit
//   of debounced takes the synchronised value only if it matches the value
//   sampled on the previous tick. db_period == 0 bypasses the filter.
// Ports:
//   clk        : system clock
//   reset_n    : asynchronous active-low reset
//   in_port    : raw asynchronous inputs
//   db_period  : debounce period in cycles, 0 = bypass
//   db_restart : pulse on a db_period write; restarts prescaler and samples
//   debounced  : filtered inputs (registered)
// ---------------------------------------------------------------------------
module nios_system_gpio_sync_debounce #(
   parameter int WIDTH       = 8,
   parameter int SYNC_STAGES = 2,
   parameter int DB_W        = 16
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [WIDTH-1:0] in_port,
   input  logic [DB_W-1:0]  db_period,
   input  logic             db_restart,
   output logic [WIDTH-1:0] debounced
);

   logic [WIDTH-1:0] sync_q [SYNC_STAGES];
   logic [WIDTH-1:0] synced;
   logic [DB_W-1:0]  presc_q;
   logic [DB_W-1:0]  period_last;
   logic [WIDTH-1:0] sample_q;
   logic [WIDTH-1:0] agree;
   logic             bypass;
   logic             tick;

   // NOTE: every synchroniser stage is reset, not just the last one, so no
   // stale input level can leak out of the chain after reset is released.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
      end else begin
         // NOTE: non-blocking assignments give true shift-register behaviour;
         // blocking ones would collapse the chain into a single flop.
         sync_q[0] <= in_port;
         for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      end
   end

   assign synced      = sync_q[SYNC_STAGES-1];
   assign bypass      = (db_period == '0);
   assign period_last = db_period - DB_W'(1);
   // >= keeps the counter from running away if the period ever shrinks
   // below the current count.
   assign tick        = !bypass && (presc_q >= period_last);
   assign agree       = ~(synced ^ sample_q);

   // Prescaler and tick samples.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         presc_q  <= '0;
         sample_q <= '0;
      end else if (db_restart) begin
         presc_q  <= '0;
         sample_q <= '0;
      end else if (bypass) begin
         presc_q  <= '0;
      end else if (tick) begin
         presc_q  <= '0;
         sample_q <= synced;
      end else begin
         presc_q  <= presc_q + DB_W'(1);
      end
   end

   // Debounced state: follows synced in bypass, otherwise only bits that
   // agree with the previous tick sample are updated. A db_period write
   // leaves the current value untouched.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         debounced <= '0;
      end else if (bypass) begin
         debounced <= synced;
      end else if (tick && !db_restart) begin
         debounced <= (synced & agree) | (debounced & ~agree);
      end
   end

endmodule

// File: rtl/nios_system_gpio_irq_ctrl.sv
// ---------------------------------------------------------------------------
// nios_system_gpio_irq_ctrl
//   Avalon-MM input port with per-bit edge capture and a single level IRQ
//   for the Nios II.
// Parameters:
//   WIDTH       : number of input bits, 1..32
//   SYNC_STAGES : synchroniser depth, >= 2
//   DB_W        : width of the debounce period register
//   IRQ_MODE    : IRQ_MODE_LEVEL (debounced input) or IRQ_MODE_EDGE (edgecap)
// Ports:
//   clk     : system clock
//   reset_n : asynchronous active-low reset
//   bus     : Avalon-MM slave (address, chipselect, write_n, writedata,
//             readdata)
//   in_port : asynchronous external inputs
//   irq     : registered interrupt request, active high
// ---------------------------------------------------------------------------
module nios_system_gpio_irq_ctrl
   import nios_system_gpio_pkg::*;
#(
   parameter int WIDTH       = 8,
   parameter int SYNC_STAGES = 2,
   parameter int DB_W        = 16,
   parameter int IRQ_MODE    = IRQ_MODE_EDGE
) (
   input  logic                         clk,
   input  logic                         reset_n,
   nios_system_gpio_irq_ctrl_if.slave   bus,
   input  logic [WIDTH-1:0]             in_port,
   output logic                         irq
);

   logic [WIDTH-1:0] irq_mask_q;
   logic [WIDTH-1:0] edgecap_q;
   logic [WIDTH-1:0] rise_en_q;
   logic [WIDTH-1:0] fall_en_q;
   logic [DB_W-1:0]  db_period_q;
   logic [WIDTH-1:0] debounced;
   logic [WIDTH-1:0] prev_q;
   logic [WIDTH-1:0] rise;
   logic [WIDTH-1:0] fall;
   logic [WIDTH-1:0] edge_clr;
   logic [WIDTH-1:0] irq_src;
   logic [31:0]      rd_mux;
   logic             wr;
   logic             wr_dbp;
   logic             unused_wdata;

   assign wr     = bus.chipselect && !bus.write_n;
   assign wr_dbp = wr && (bus.address == ADDR_DBP);

   // Upper write-data bits beyond WIDTH/DB_W have no destination.
   assign unused_wdata = ^bus.writedata;

   nios_system_gpio_sync_debounce #(
      .WIDTH       (WIDTH),
      .SYNC_STAGES (SYNC_STAGES),
      .DB_W        (DB_W)
   ) u_sync_debounce (
      .clk        (clk),
      .reset_n    (reset_n),
      .in_port    (in_port),
      .db_period  (db_period_q),
      .db_restart (wr_dbp),
      .debounced  (debounced)
   );

   // Plain read/write configuration registers.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         irq_mask_q  <= '0;
         rise_en_q   <= '1;
         fall_en_q   <= '0;
         db_period_q <= '0;
      end else if (wr) begin
         case (bus.address)
            ADDR_MASK: irq_mask_q  <= bus.writedata[WIDTH-1:0];
            ADDR_RISE: rise_en_q   <= bus.writedata[WIDTH-1:0];
            ADDR_FALL: fall_en_q   <= bus.writedata[WIDTH-1:0];
            ADDR_DBP:  db_period_q <= bus.writedata[DB_W-1:0];
            default:   ;
         endcase
      end
   end

   // Edge detection on the debounced signal.
   assign rise     = debounced & ~prev_q & rise_en_q;
   assign fall     = ~debounced & prev_q & fall_en_q;
   assign edge_clr = (wr && (bus.address == ADDR_EDGE)) ? bus.writedata[WIDTH-1:0]
                                                       : '0;

   // A new edge in the same cycle as its W1C clear wins: OR-ing the set
   // terms after the clear mask keeps the bit at 1.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         prev_q    <= '0;
         edgecap_q <= '0;
      end else begin
         prev_q    <= debounced;
         edgecap_q <= (edgecap_q & ~edge_clr) | rise | fall;
      end
   end

   assign irq_src = (IRQ_MODE == IRQ_MODE_EDGE) ? edgecap_q : debounced;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) irq <= 1'b0;
      else          irq <= |(irq_src & irq_mask_q);
   end

   // Read mux; readdata is refreshed every cycle from address alone.
   always_comb begin
      // NOTE: the default before the case keeps this combinational; leaving
      // rd_mux unassigned on some path would infer a latch.
      rd_mux = '0;
      case (bus.address)
         ADDR_DATA: rd_mux[WIDTH-1:0] = debounced;
         ADDR_MASK: rd_mux[WIDTH-1:0] = irq_mask_q;
         ADDR_EDGE: rd_mux[WIDTH-1:0] = edgecap_q;
         ADDR_RISE: rd_mux[WIDTH-1:0] = rise_en_q;
         ADDR_FALL: rd_mux[WIDTH-1:0] = fall_en_q;
         ADDR_DBP:  rd_mux[DB_W-1:0]  = db_period_q;
         default:   rd_mux = '0;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) bus.readdata <= '0;
      else          bus.readdata <= rd_mux;
   end

endmodule

// File: tb/tb_nios_system_gpio_irq_ctrl.sv
// ---------------------------------------------------------------------------
// tb_nios_system_gpio_irq_ctrl
//   Self-checking bench for nios_system_gpio_irq_ctrl. dut_e runs in edge
//   mode, dut_l in level mode; both share clk and reset_n. Inputs are driven
//   on the falling edge and outputs sampled on the following falling edge.
// ---------------------------------------------------------------------------
module tb_nios_system_gpio_irq_ctrl;
   import nios_system_gpio_pkg::*;

   logic       clk = 1'b0;
   logic       reset_n;
   logic [7:0] in_e;
   logic [7:0] in_l;
   logic       irq_e;
   logic       irq_l;

   always #5 clk = ~clk;

   nios_system_gpio_irq_ctrl_if bus_e ();
   nios_system_gpio_irq_ctrl_if bus_l ();

   nios_system_gpio_irq_ctrl #(
      .WIDTH(8), .SYNC_STAGES(2), .DB_W(16), .IRQ_MODE(IRQ_MODE_EDGE)
   ) dut_e (
      .clk(clk), .reset_n(reset_n), .bus(bus_e), .in_port(in_e), .irq(irq_e)
   );

   nios_system_gpio_irq_ctrl #(
      .WIDTH(8), .SYNC_STAGES(2), .DB_W(16), .IRQ_MODE(IRQ_MODE_LEVEL)
   ) dut_l (
      .clk(clk), .reset_n(reset_n), .bus(bus_l), .in_port(in_l), .irq(irq_l)
   );

   typedef struct {
      logic [2:0]  addr;
      logic [31:0] wdata;
      logic [31:0] exp;
      string       name;
   } vec_t;

   typedef struct {
      logic [31:0] exp;
      string       name;
   } sb_t;

   sb_t  sb_q[$];
   int   n_checks = 0;
   int   n_err    = 0;
   vec_t rst_vec[8];
   vec_t rw_vec[8];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   function automatic logic [31:0] rdata(input bit lvl);
      return lvl ? bus_l.readdata : bus_e.readdata;
   endfunction

   task automatic set_addr(input bit lvl, input logic [2:0] a);
      if (lvl) bus_l.address = a;
      else     bus_e.address = a;
   endtask

   task automatic wr(input bit lvl, input logic [2:0] a, input logic [31:0] d);
      if (lvl) begin
         bus_l.address = a; bus_l.writedata = d; bus_l.chipselect = 1'b1; bus_l.write_n = 1'b0;
      end else begin
         bus_e.address = a; bus_e.writedata = d; bus_e.chipselect = 1'b1; bus_e.write_n = 1'b0;
      end
      tick(1);
      if (lvl) begin bus_l.chipselect = 1'b0; bus_l.write_n = 1'b1; end
      else     begin bus_e.chipselect = 1'b0; bus_e.write_n = 1'b1; end
   endtask

   // Single read through the scoreboard.
   task automatic rd(input bit lvl, input logic [2:0] a, input logic [31:0] exp, input string name);
      sb_t e;
      sb_q.push_back('{exp, name});
      set_addr(lvl, a);
      tick(1);
      e = sb_q.pop_front();
      check(e.name, rdata(lvl), e.exp);
   endtask

   // Back-to-back reads: a new address every cycle, each result compared
   // one cycle later against the expectation queued when it was issued.
   task automatic rd_pipe(input bit lvl, input vec_t v[8]);
      for (int i = 0; i <= 8; i++) begin
         if (sb_q.size() != 0) begin
            sb_t e = sb_q.pop_front();
            check(e.name, rdata(lvl), e.exp);
         end
         if (i < 8) begin
            set_addr(lvl, v[i].addr);
            sb_q.push_back('{v[i].exp, v[i].name});
         end
         tick(1);
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      rst_vec[0] = '{3'd0, 32'h0, 32'h0000_0000, "rst_data"};
      rst_vec[1] = '{3'd1, 32'h0, 32'h0000_0000, "rst_addr1"};
      rst_vec[2] = '{3'd2, 32'h0, 32'h0000_0000, "rst_mask"};
      rst_vec[3] = '{3'd3, 32'h0, 32'h0000_0000, "rst_edge"};
      rst_vec[4] = '{3'd4, 32'h0, 32'h0000_00FF, "rst_rise"};
      rst_vec[5] = '{3'd5, 32'h0, 32'h0000_0000, "rst_fall"};
      rst_vec[6] = '{3'd6, 32'h0, 32'h0000_0000, "rst_dbp"};
      rst_vec[7] = '{3'd7, 32'h0, 32'h0000_0000, "rst_addr7"};

      rw_vec[0]  = '{3'd2, 32'hFFFF_FFA5, 32'h0000_00A5, "rw_mask"};
      rw_vec[1]  = '{3'd3, 32'hFFFF_FFFF, 32'h0000_0000, "rw_edge_w1c"};
      rw_vec[2]  = '{3'd4, 32'h0000_013C, 32'h0000_003C, "rw_rise"};
      rw_vec[3]  = '{3'd5, 32'hFFFF_FFC3, 32'h0000_00C3, "rw_fall"};
      rw_vec[4]  = '{3'd6, 32'h1234_ABCD, 32'h0000_ABCD, "rw_dbp"};
      rw_vec[5]  = '{3'd1, 32'hFFFF_FFFF, 32'h0000_0000, "rw_addr1"};
      rw_vec[6]  = '{3'd7, 32'hFFFF_FFFF, 32'h0000_0000, "rw_addr7"};
      rw_vec[7]  = '{3'd0, 32'h0000_00FF, 32'h0000_0000, "rw_data_ro"};

      bus_e.address = '0; bus_e.chipselect = 1'b0; bus_e.write_n = 1'b1; bus_e.writedata = '0;
      bus_l.address = '0; bus_l.chipselect = 1'b0; bus_l.write_n = 1'b1; bus_l.writedata = '0;
      in_e    = '0;
      in_l    = '0;
      reset_n = 1'b0;
      tick(2);
      reset_n = 1'b1;
      tick(1);

      // 1. Reset values.
      check("rst_irq_e", {31'd0, irq_e}, 32'd0);
      check("rst_irq_l", {31'd0, irq_l}, 32'd0);
      rd_pipe(1'b0, rst_vec);

      // Register read/write table, then restore working defaults.
      for (int i = 0; i < 8; i++) wr(1'b0, rw_vec[i].addr, rw_vec[i].wdata);
      rd_pipe(1'b0, rw_vec);
      wr(1'b0, ADDR_MASK, 32'h01);
      wr(1'b0, ADDR_RISE, 32'hFF);
      wr(1'b0, ADDR_FALL, 32'h00);
      wr(1'b0, ADDR_DBP,  32'h00);
      tick(4);

      // 2. Bypass latency: edgecap after 4 edges, irq one edge later.
      bus_e.address = ADDR_EDGE;
      in_e[0] = 1'b1;
      tick(4);
      check("lat_edge_before", rdata(1'b0), 32'h00);
      check("lat_irq_before", {31'd0, irq_e}, 32'd0);
      tick(1);
      check("lat_edge_set", rdata(1'b0), 32'h01);
      check("lat_irq_set", {31'd0, irq_e}, 32'd1);
      wr(1'b0, ADDR_EDGE, 32'h01);
      check("w1c_irq_hold", {31'd0, irq_e}, 32'd1);
      tick(1);
      check("w1c_irq_drop", {31'd0, irq_e}, 32'd0);
      rd(1'b0, ADDR_EDGE, 32'h00, "w1c_edge");

      // 3. Falling-edge capture only.
      wr(1'b0, ADDR_RISE, 32'h00);
      wr(1'b0, ADDR_FALL, 32'h80);
      in_e[7] = 1'b1;
      tick(6);
      rd(1'b0, ADDR_EDGE, 32'h00, "fall_no_rise");
      in_e[7] = 1'b0;
      tick(6);
      rd(1'b0, ADDR_EDGE, 32'h80, "fall_capture");
      check("fall_irq_masked", {31'd0, irq_e}, 32'd0);
      wr(1'b0, ADDR_EDGE, 32'h80);
      wr(1'b0, ADDR_RISE, 32'hFF);
      wr(1'b0, ADDR_FALL, 32'h00);
      rd(1'b0, ADDR_EDGE, 32'h00, "fall_cleared");

      // 4. Debounce: a 3-cycle glitch is filtered, a held level passes.
      wr(1'b0, ADDR_DBP, 32'd10);
      in_e[2] = 1'b1;
      tick(3);
      in_e[2] = 1'b0;
      tick(30);
      rd(1'b0, ADDR_DATA, 32'h01, "db_glitch_data");
      rd(1'b0, ADDR_EDGE, 32'h00, "db_glitch_edge");
      in_e[2] = 1'b1;
      tick(5);
      rd(1'b0, ADDR_DATA, 32'h01, "db_hold_early");
      tick(19);
      rd(1'b0, ADDR_DATA, 32'h05, "db_hold_passed");
      rd(1'b0, ADDR_EDGE, 32'h04, "db_hold_edge");
      wr(1'b0, ADDR_EDGE, 32'h04);
      wr(1'b0, ADDR_DBP,  32'h00);
      tick(4);

      // 5. Clear and new rising edge of bit0 in the same cycle.
      in_e[0] = 1'b0;
      tick(6);
      in_e[0] = 1'b1;
      tick(6);
      check("coll_pre_irq", {31'd0, irq_e}, 32'd1);
      rd(1'b0, ADDR_EDGE, 32'h01, "coll_pre_edge");
      in_e[0] = 1'b0;
      tick(6);
      in_e[0] = 1'b1;
      tick(3);
      wr(1'b0, ADDR_EDGE, 32'h01);
      check("coll_irq_0", {31'd0, irq_e}, 32'd1);
      tick(1);
      check("coll_irq_1", {31'd0, irq_e}, 32'd1);
      rd(1'b0, ADDR_EDGE, 32'h01, "coll_edge");

      // Mask to 0 drops irq but keeps edgecap; mask back raises it again.
      wr(1'b0, ADDR_MASK, 32'h00);
      check("mask0_irq_hold", {31'd0, irq_e}, 32'd1);
      tick(1);
      check("mask0_irq_drop", {31'd0, irq_e}, 32'd0);
      rd(1'b0, ADDR_EDGE, 32'h01, "mask0_edge_kept");
      wr(1'b0, ADDR_MASK, 32'h01);
      tick(1);
      check("mask1_irq_back", {31'd0, irq_e}, 32'd1);

      // 6. Level mode, then reset in the middle of an active irq.
      wr(1'b1, ADDR_MASK, 32'h04);
      in_l[2] = 1'b1;
      tick(3);
      check("lvl_irq_before", {31'd0, irq_l}, 32'd0);
      tick(1);
      check("lvl_irq_set", {31'd0, irq_l}, 32'd1);
      wr(1'b1, ADDR_MASK, 32'h00);
      check("lvl_mask0_hold", {31'd0, irq_l}, 32'd1);
      tick(1);
      check("lvl_mask0_drop", {31'd0, irq_l}, 32'd0);
      wr(1'b1, ADDR_MASK, 32'h04);
      tick(1);
      check("lvl_mask_back", {31'd0, irq_l}, 32'd1);
      check("pre_rst_irq_e", {31'd0, irq_e}, 32'd1);

      in_e = '0;
      #2 reset_n = 1'b0;
      #1;
      check("midrst_irq_l", {31'd0, irq_l}, 32'd0);
      check("midrst_irq_e", {31'd0, irq_e}, 32'd0);
      check("midrst_rdata_l", bus_l.readdata, 32'd0);
      @(negedge clk);
      reset_n = 1'b1;
      rd(1'b1, ADDR_MASK, 32'h00, "postrst_mask_l");
      rd(1'b0, ADDR_EDGE, 32'h00, "postrst_edge_e");
      rd(1'b0, ADDR_RISE, 32'hFF, "postrst_rise_e");
      tick(5);
      check("postrst_irq_l", {31'd0, irq_l}, 32'd0);
      check("postrst_irq_e", {31'd0, irq_e}, 32'd0);
      rd(1'b1, ADDR_DATA, 32'h04, "postrst_data_l");

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
